// File: rtl/datapath_pkg.sv
// Shared datapath types and sizes for the 16-bit core.
// Ports: none (package of constants, typedefs and a helper).
package datapath_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 4;
   localparam int NUM_REGS   = 16;

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ADDR_WIDTH-1:0] reg_addr_t;

   // True when an address names an implemented register.
   function automatic logic reg_valid(input reg_addr_t a);
      return int'(a) < NUM_REGS;
   endfunction

endpackage

// File: rtl/register_file_if.sv
// Decode/writeback side bus of the register file.
// master: drives write/read addresses and data; slave: returns read data.
interface register_file_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);

   logic                  regwrite;
   logic [ADDR_WIDTH-1:0] WriteReg;
   logic [DATA_WIDTH-1:0] WriteData;
   logic [ADDR_WIDTH-1:0] Reg1;
   logic [ADDR_WIDTH-1:0] Reg2;
   logic [DATA_WIDTH-1:0] ReadData1;
   logic [DATA_WIDTH-1:0] ReadData2;

   modport master (
      output regwrite, WriteReg, WriteData,
      output Reg1, Reg2,
      input  ReadData1, ReadData2
   );

   modport slave (
      input  regwrite, WriteReg, WriteData,
      input  Reg1, Reg2,
      output ReadData1, ReadData2
   );

endinterface

// File: rtl/regfile_read_port.sv
// Combinational read port: selects one register by address.
// Ports: regs (storage array), addr (read address), data (selected value, 0 if unimplemented).
module regfile_read_port
   import datapath_pkg::*;
#(
   parameter int DATA_WIDTH = datapath_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = datapath_pkg::ADDR_WIDTH,
   parameter int NUM_REGS   = datapath_pkg::NUM_REGS
) (
   input  logic [DATA_WIDTH-1:0] regs [NUM_REGS],
   input  logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] data
);

   localparam int SPAN = 2 ** ADDR_WIDTH;

   // Full address space; unimplemented slots are tied to zero so the
   // final select never indexes past the storage array.
   logic [DATA_WIDTH-1:0] slot [SPAN];

   for (genvar i = 0; i < SPAN; i++) begin : g_slot
      if (i < NUM_REGS) begin : g_impl
         assign slot[i] = regs[i];
      end else begin : g_zero
         assign slot[i] = '0;
      end
   end

   assign data = slot[addr];

endmodule

// File: rtl/register_file.sv
// 16x16 register file: two combinational read ports, one write port.
// Ports: clock, reset (async active-low), bus (slave: write enable/addr/data, read addrs/data).
module register_file
   import datapath_pkg::*;
#(
   parameter int DATA_WIDTH = datapath_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = datapath_pkg::ADDR_WIDTH,
   parameter int NUM_REGS   = datapath_pkg::NUM_REGS
) (
   input  logic            clock,
   input  logic            reset,
   register_file_if.slave  bus
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   wr_sel;

   // One-hot write decode; addresses past NUM_REGS match no register.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
      assign wr_sel[i] = bus.regwrite &&
                         (bus.WriteReg == ADDR_WIDTH'(i));
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel[i]) begin
               regs[i] <= bus.WriteData;
            end
         end
      end
   end

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_rd1 (
      .regs (regs),
      .addr (bus.Reg1),
      .data (bus.ReadData1)
   );

   regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_REGS   (NUM_REGS)
   ) u_rd2 (
      .regs (regs),
      .addr (bus.Reg2),
      .data (bus.ReadData2)
   );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file against an array model.
// Ports: none (top-level bench).
module tb_register_file;
   import datapath_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;

   register_file_if #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) bus ();

   register_file dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   int    n_chk  = 0;
   int    n_pass = 0;
   data_t model [NUM_REGS];

   task automatic check(input string tag, input data_t got,
                        input data_t exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic data_t ref_rd(input reg_addr_t a);
      return reg_valid(a) ? model[int'(a)] : '0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
   endtask

   // Advance one rising edge, apply the write rule to the model,
   // then step just past the edge.
   task automatic tick();
      @(posedge clock);
      if (reset === 1'b1 && bus.regwrite === 1'b1 &&
          reg_valid(bus.WriteReg))
         model[int'(bus.WriteReg)] = bus.WriteData;
      if (reset === 1'b0) model_clear();
      #1;
   endtask

   task automatic wr(input reg_addr_t a, input data_t d);
      bus.regwrite  = 1'b1;
      bus.WriteReg  = a;
      bus.WriteData = d;
      tick();
      bus.regwrite  = 1'b0;
   endtask

   task automatic rd(input string tag, input reg_addr_t a1,
                     input reg_addr_t a2);
      bus.Reg1 = a1;
      bus.Reg2 = a2;
      #1;
      check({tag, ".rd1"}, bus.ReadData1, ref_rd(a1));
      check({tag, ".rd2"}, bus.ReadData2, ref_rd(a2));
   endtask

   task automatic async_reset();
      reset = 1'b0;
      model_clear();
      #1;
   endtask

   initial begin
      bus.regwrite  = 1'b0;
      bus.WriteReg  = '0;
      bus.WriteData = '0;
      bus.Reg1      = '0;
      bus.Reg2      = '0;
      model_clear();
      tick();
      #2 reset = 1'b1;
      tick();

      rd("reset_state", 4'd0, 4'd15);

      wr(4'd3, 16'hAAAA);
      rd("r3_written", 4'd3, 4'd3);
      check("r3_literal", bus.ReadData1, 16'hAAAA);
      async_reset();
      check("async_clr", bus.ReadData1, 16'h0000);
      reset = 1'b1;
      tick();

      // No bypass: old value visible while the write is pending.
      bus.regwrite  = 1'b1;
      bus.WriteReg  = 4'd1;
      bus.WriteData = 16'h0001;
      rd("pre_write", 4'd1, 4'd1);
      check("pre_write_lit", bus.ReadData1, 16'h0000);
      tick();
      bus.regwrite = 1'b0;
      rd("post_write", 4'd1, 4'd1);
      check("post_write_lit", bus.ReadData1, 16'h0001);

      wr(4'd1, 16'h0F00);
      wr(4'd0, 16'h00F0);
      rd("dual_same", 4'd1, 4'd1);
      check("dual_same_lit", bus.ReadData2, 16'h0F00);
      rd("dual_diff", 4'd0, 4'd1);
      check("dual_diff_lit", bus.ReadData1, 16'h00F0);

      bus.regwrite  = 1'b0;
      bus.WriteReg  = 4'd2;
      bus.WriteData = 16'hFFFF;
      tick();
      rd("we_off", 4'd2, 4'd2);
      check("we_off_lit", bus.ReadData1, 16'h0000);

      bus.Reg1 = 4'd1;
      wr(4'd1, 16'h2222);
      check("b2b_0", bus.ReadData1, 16'h2222);
      wr(4'd1, 16'hFFFF);
      check("b2b_1", bus.ReadData1, 16'hFFFF);
      wr(4'd1, 16'h1111);
      check("b2b_2", bus.ReadData1, 16'h1111);
      tick();
      check("b2b_hold", bus.ReadData1, 16'h1111);

      // Reset held across an edge with a write request.
      wr(4'd4, 16'h5555);
      reset         = 1'b0;
      bus.regwrite  = 1'b1;
      bus.WriteReg  = 4'd4;
      bus.WriteData = 16'h1234;
      tick();
      bus.regwrite = 1'b0;
      #1 reset = 1'b1;
      tick();
      rd("rst_prio", 4'd4, 4'd1);
      check("rst_prio_lit", bus.ReadData1, 16'h0000);

      for (int n = 0; n < 400; n++) begin
         bus.regwrite  = 1'($urandom_range(0, 1));
         bus.WriteReg  = reg_addr_t'($urandom);
         bus.WriteData = data_t'($urandom);
         rd("rnd_pre", reg_addr_t'($urandom), bus.WriteReg);
         tick();
         rd("rnd_post", bus.WriteReg, reg_addr_t'($urandom));
         if ($urandom_range(0, 49) == 0) begin
            async_reset();
            rd("rnd_rst", reg_addr_t'($urandom),
               reg_addr_t'($urandom));
            reset = 1'b1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
